// File: rtl/ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl
//
// Burst controller that sits directly in front of a single-port RAM with a
// registered (1-cycle) read port. A command (base address, length,
// direction) runs one burst:
//   - write burst: bytes from the s_* stream are written to consecutive RAM
//     addresses, one byte per accepted handshake.
//   - read burst: each byte is issued to the RAM, its registered data is
//     captured into m_data, then offered on the m_* stream.
// Burst addresses wrap modulo DEPTH. len=0 is a no-op burst and len above
// DEPTH is clamped to DEPTH.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The producer holds valid and data stable until the
// transfer. s_ready depends only on state; m_valid/m_data are stable while
// m_valid is high and m_ready is low.
//
// Ports:
//   clk        rising-edge clock, shared with the RAM
//   rst        asynchronous active-low reset
//   start      command strobe, sampled only in IDLE
//   mode       1 = write burst, 0 = read burst
//   base_addr  first RAM address of the burst
//   len        byte count (0 = no-op, clamped to DEPTH)
//   s_valid    write-stream byte valid
//   s_data     write-stream byte
//   s_ready    write-stream ready
//   m_valid    read-stream byte valid
//   m_data     read-stream byte
//   m_ready    read-stream consumer ready
//   busy       high whenever the controller is not IDLE
//   done       one-cycle pulse at burst end
//   ram_en     RAM enable
//   ram_wr_rd  RAM direction (1 = write)
//   ram_addr   RAM address
//   ram_din    RAM write data
//   ram_dout   RAM read data (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_wr_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_OUT   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [ADDR_W:0]     len_clamped;

  assign len_clamped = (len > DEPTH_C) ? DEPTH_C : len;

  // Next-state logic. Address is ADDR_W bits wide and DEPTH == 2**ADDR_W,
  // so the natural overflow of addr_q + 1 gives the modulo-DEPTH wrap.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          cnt_d  = len_clamped;
          if (len_clamped == '0) state_d = S_DONE;
          else if (mode)         state_d = S_WR;
          else                   state_d = S_RD_ISSUE;
        end
      end
      S_WR: begin
        if (s_valid) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) state_d = S_DONE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // RAM data for the address issued last cycle is valid now.
        m_data_d = ram_dout;
        state_d  = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (m_ready) begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == CNT_ONE) ? S_DONE : S_RD_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
    end
  end

  // Outputs are decoded from state so that an asynchronous reset drops
  // ram_en in the same instant, before any in-flight write is committed.
  always_comb begin
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ram_en    = 1'b0;
    ram_wr_rd = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state_q)
      S_WR: begin
        s_ready   = 1'b1;
        ram_wr_rd = 1'b1;
        ram_en    = s_valid;
        if (s_valid) begin
          ram_addr = addr_q;
          ram_din  = s_data;
        end
      end
      S_RD_ISSUE: begin
        ram_en   = 1'b1;
        ram_addr = addr_q;
      end
      S_RD_OUT: m_valid = 1'b1;
      default: ;
    endcase
  end

  assign m_data = m_data_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start, mode;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          busy, done;
  logic          ram_en, ram_wr_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .len(len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
    .done(done), .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // ---------------- RAM model (32x8, registered read) ----------------
  logic [DW-1:0]    ram_mem [DEPTH];
  bit               ram_loaded = 1'b0;
  int               acc_cnt = 0;
  logic [AW+DW-1:0] act_q[$];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < DEPTH; k++) ram_mem[k] <= 8'(k * 37 + 5);
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      acc_cnt <= acc_cnt + 1;
      if (ram_wr_rd) begin
        ram_mem[ram_addr] <= ram_din;
        act_q.push_back({ram_addr, ram_din});
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    wr_data_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_wr_log();
    chk("wr_log_count", act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0)
      chk("wr_log_entry", act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic junk_cmd();
    start     = ($urandom_range(0, 3) == 0);
    mode      = 1'($urandom);
    base_addr = AW'($urandom);
    len       = (AW+1)'($urandom_range(1, 40));
  endtask

  // Called just after a negedge while IDLE; returns just after the next negedge.
  task automatic issue(input logic m, input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; mode = m; base_addr = b; len = n;
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expects DONE on entry; a command offered during DONE must be ignored.
  task automatic finish_burst();
    start = 1'b1; mode = 1'($urandom); base_addr = AW'($urandom); len = 6'd1;
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_en", ram_en, 0);
    chk("done_s_ready", s_ready, 0);
    chk("done_m_valid", m_valid, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_en", ram_en, 0);
  endtask

  task automatic write_burst(input logic [AW-1:0] base, input logic [AW:0] n_len,
                             input int stall_pct, input logic [5:0] pat,
                             input bit use_pat, input int abort_at);
    int n_eff, i, cyc;
    logic v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit aborted;
    n_eff = (n_len > 6'(DEPTH)) ? DEPTH : int'(n_len);
    issue(1'b1, base, n_len);
    i = 0; cyc = 0; aborted = 1'b0;
    while (i < n_eff && cyc < 2000 && !aborted) begin
      if (abort_at >= 0 && i == abort_at) begin
        rst = 1'b0; s_valid = 1'b1; start = 1'b0;
        #1;
        chk("rst_en", ram_en, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        #1;
        chk("rst_release_busy", busy, 0);
        chk("rst_m_data", m_data, 0);
        aborted = 1'b1;
      end else begin
        v = use_pat ? pat[cyc % 6] : ($urandom_range(0, 99) >= stall_pct);
        a = base + i[AW-1:0];
        d = (wr_data_q.size() > 0) ? wr_data_q[0] : DW'($urandom);
        s_valid = v; s_data = d;
        junk_cmd();
        #1;
        chk("wr_s_ready", s_ready, 1);
        chk("wr_busy", busy, 1);
        chk("wr_m_valid", m_valid, 0);
        chk("wr_wr_rd", ram_wr_rd, 1);
        chk("wr_en", ram_en, v);
        chk("wr_addr", ram_addr, v ? a : 0);
        chk("wr_din", ram_din, v ? d : 0);
        if (v) begin
          if (wr_data_q.size() > 0) void'(wr_data_q.pop_front());
          ref_mem[a] = d;
          exp_q.push_back({a, d});
          i++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!aborted) begin
      if (i < n_eff) chk("wr_timeout", i, n_eff);
      s_valid = 1'b0;
      finish_burst();
    end
    compare_wr_log();
  endtask

  task automatic read_burst(input logic [AW-1:0] base, input logic [AW:0] n_len,
                            input int rdy_pct, input int hold_first);
    int n_eff, i, hold;
    logic r;
    logic [AW-1:0] a;
    bit timeout;
    n_eff = (n_len > 6'(DEPTH)) ? DEPTH : int'(n_len);
    issue(1'b0, base, n_len);
    i = 0; timeout = 1'b0;
    while (i < n_eff && !timeout) begin
      a = base + i[AW-1:0];
      junk_cmd();
      #1;
      chk("rd_issue_en", ram_en, 1);
      chk("rd_issue_wr_rd", ram_wr_rd, 0);
      chk("rd_issue_addr", ram_addr, a);
      chk("rd_issue_m_valid", m_valid, 0);
      chk("rd_issue_s_ready", s_ready, 0);
      @(negedge clk);
      junk_cmd();
      #1;
      chk("rd_wait_en", ram_en, 0);
      chk("rd_wait_m_valid", m_valid, 0);
      chk("rd_wait_busy", busy, 1);
      @(negedge clk);
      hold = 0;
      r = 1'b0;
      while (!r && !timeout) begin
        if (i == 0 && hold < hold_first) r = 1'b0;
        else r = ($urandom_range(0, 99) >= rdy_pct);
        m_ready = r;
        junk_cmd();
        #1;
        chk("rd_out_m_valid", m_valid, 1);
        chk("rd_out_data", m_data, ref_mem[a]);
        chk("rd_out_en", ram_en, 0);
        chk("rd_out_addr", ram_addr, 0);
        @(negedge clk);
        hold++;
        if (hold > 200) begin
          chk("rd_timeout", hold, 0);
          timeout = 1'b1;
        end
      end
      i++;
    end
    m_ready = 1'b0;
    if (!timeout) finish_burst();
    compare_wr_log();
  endtask

  // ---------------- directed + random sequence ----------------
  int acc0;

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'(k * 37 + 5);
    rst = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_en", ram_en, 0);
    chk("reset_wr_rd", ram_wr_rd, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_din", ram_din, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a write burst after two handshakes.
    write_burst(5'd0, 6'd4, 0, 6'd0, 1'b0, 2);

    // Write then read back.
    wr_data_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    write_burst(5'd3, 6'd4, 0, 6'd0, 1'b0, -1);
    read_burst(5'd3, 6'd4, 0, 0);

    // Wrap-around across address 31 -> 0.
    wr_data_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    write_burst(5'd30, 6'd4, 0, 6'd0, 1'b0, -1);
    read_burst(5'd30, 6'd4, 0, 0);

    // Backpressure on the first read byte.
    read_burst(5'd4, 6'd2, 0, 5);

    // Input stall pattern 1,0,0,1,0,1.
    write_burst(5'd10, 6'd3, 0, 6'b101001, 1'b1, -1);
    read_burst(5'd10, 6'd3, 0, 0);

    // len = 0: no RAM access.
    acc0 = acc_cnt;
    write_burst(5'd7, 6'd0, 0, 6'd0, 1'b0, -1);
    read_burst(5'd7, 6'd0, 0, 0);
    chk("len0_accesses", acc_cnt - acc0, 0);

    // len = 40 clamps to 32 accesses per burst.
    acc0 = acc_cnt;
    write_burst(5'd17, 6'd40, 20, 6'd0, 1'b0, -1);
    chk("clamp_wr_accesses", acc_cnt - acc0, 32);
    acc0 = acc_cnt;
    read_burst(5'd9, 6'd40, 20, 0);
    chk("clamp_rd_accesses", acc_cnt - acc0, 32);

    // Random bursts.
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1)
        write_burst(AW'($urandom), (AW+1)'($urandom_range(0, 40)),
                    $urandom_range(0, 60), 6'd0, 1'b0, -1);
      else
        read_burst(AW'($urandom), (AW+1)'($urandom_range(0, 40)),
                   $urandom_range(0, 60), $urandom_range(0, 3));
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
